// File: rtl/genel_bolucu.sv
// genel_bolucu: restoring integer divider, BIT_PER_CYCLE quotient bits per cycle (rev 1.0).
// Optional GENEL_BOLUCU_ERKEN_CIKIS_EN: skip leading-zero digit groups of |dividend|.
`default_nettype none

module genel_bolucu #(
  parameter int VERI_BIT      = 32,
  parameter int BIT_PER_CYCLE = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [3:0]          islev_kodu_i,
  input  logic [VERI_BIT-1:0] islec0_i,
  input  logic [VERI_BIT-1:0] islec1_i,
  input  logic                islem_gecerli_i,
  output logic                islem_hazir_o,
  input  logic                iptal_i,
  output logic [VERI_BIT-1:0] bolum_o,
  output logic [VERI_BIT-1:0] kalan_o,
  output logic                sonuc_gecerli_o,
  input  logic                sonuc_hazir_i
);

  localparam int c_TUR     = VERI_BIT / BIT_PER_CYCLE;
  localparam int c_SAYAC_W = $clog2(c_TUR + 1);

  typedef enum logic [1:0] {
    BEKLE  = 2'd0,
    BOL    = 2'd1,
    DUZELT = 2'd2,
    SONUC  = 2'd3
  } durum_t;

  durum_t                r_durum;
  logic [VERI_BIT-1:0]   r_bolum;
  logic [VERI_BIT-1:0]   r_kalan;
  logic                  r_sonuc_gecerli;
  logic [VERI_BIT-1:0]   r_bolunen;
  logic [VERI_BIT-1:0]   r_artik;
  logic [VERI_BIT-1:0]   r_bolen;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic [c_SAYAC_W-1:0]  r_sayac;

  logic                  w_isaretli;
  logic                  w_tek_sicak;
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic [VERI_BIT-1:0]   w_mutlak_a;
  logic [VERI_BIT-1:0]   w_mutlak_b;
  logic                  w_sifir_bolen;
  logic                  w_tasma;
  logic [c_SAYAC_W-1:0]  w_tur;
  logic [VERI_BIT-1:0]   w_bolunen_ilk;

  assign w_isaretli    = islev_kodu_i[0] | islev_kodu_i[2];
  assign w_tek_sicak   = (islev_kodu_i == 4'h1) || (islev_kodu_i == 4'h2) ||
                         (islev_kodu_i == 4'h4) || (islev_kodu_i == 4'h8);
  assign w_a_neg       = w_isaretli & islec0_i[VERI_BIT-1];
  assign w_b_neg       = w_isaretli & islec1_i[VERI_BIT-1];
  assign w_mutlak_a    = w_a_neg ? -islec0_i : islec0_i;
  assign w_mutlak_b    = w_b_neg ? -islec1_i : islec1_i;
  assign w_sifir_bolen = ~|islec1_i;
  assign w_tasma       = w_isaretli && (islec0_i == {1'b1, {(VERI_BIT-1){1'b0}}}) && (&islec1_i);

`ifdef GENEL_BOLUCU_ERKEN_CIKIS_EN
  // Highest non-zero digit group sets the iteration count; the dividend is pre-aligned to it.
  always_comb begin
    w_tur = c_SAYAC_W'(1);
    for (int g = 0; g < c_TUR; g++) begin
      if (|w_mutlak_a[g*BIT_PER_CYCLE +: BIT_PER_CYCLE]) begin
        w_tur = c_SAYAC_W'(g + 1);
      end
    end
  end
  assign w_bolunen_ilk = w_mutlak_a << (BIT_PER_CYCLE * (c_TUR - int'(w_tur)));
`else
  assign w_tur         = c_SAYAC_W'(c_TUR);
  assign w_bolunen_ilk = w_mutlak_a;
`endif

  // Partial remainder stays below the divisor, so a (VERI_BIT+1)-bit difference's MSB is the borrow.
  logic [VERI_BIT-1:0] w_art [0:BIT_PER_CYCLE];
  logic [VERI_BIT-1:0] w_blm [0:BIT_PER_CYCLE];

  assign w_art[0] = r_artik;
  assign w_blm[0] = r_bolunen;

  for (genvar k = 0; k < BIT_PER_CYCLE; k++) begin : g_adim
    logic [VERI_BIT:0] w_aday;
    logic [VERI_BIT:0] w_fark;
    assign w_aday     = {w_art[k], w_blm[k][VERI_BIT-1]};
    assign w_fark     = w_aday - {1'b0, r_bolen};
    assign w_art[k+1] = w_fark[VERI_BIT] ? w_aday[VERI_BIT-1:0] : w_fark[VERI_BIT-1:0];
    assign w_blm[k+1] = {w_blm[k][VERI_BIT-2:0], ~w_fark[VERI_BIT]};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_durum         <= BEKLE;
      r_bolum         <= '0;
      r_kalan         <= '0;
      r_sonuc_gecerli <= 1'b0;
      r_bolunen       <= '0;
      r_artik         <= '0;
      r_bolen         <= '0;
      r_neg_q         <= 1'b0;
      r_neg_r         <= 1'b0;
      r_sayac         <= '0;
    end else if (iptal_i) begin
      r_durum         <= BEKLE;
      r_sonuc_gecerli <= 1'b0;
    end else begin
      case (r_durum)
        BEKLE: begin
          if (islem_gecerli_i) begin
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_bolunen <= w_bolunen_ilk;
            r_bolen   <= w_mutlak_b;
            r_artik   <= '0;
            r_sayac   <= w_tur;
            if (!w_tek_sicak) begin
              r_bolum         <= '0;
              r_kalan         <= '0;
              r_sonuc_gecerli <= 1'b1;
              r_durum         <= SONUC;
            end else if (w_sifir_bolen) begin
              r_bolum         <= '1;
              r_kalan         <= islec0_i;
              r_sonuc_gecerli <= 1'b1;
              r_durum         <= SONUC;
            end else if (w_tasma) begin
              r_bolum         <= islec0_i;
              r_kalan         <= '0;
              r_sonuc_gecerli <= 1'b1;
              r_durum         <= SONUC;
            end else begin
              r_durum <= BOL;
            end
          end
        end
        BOL: begin
          r_artik   <= w_art[BIT_PER_CYCLE];
          r_bolunen <= w_blm[BIT_PER_CYCLE];
          r_sayac   <= r_sayac - c_SAYAC_W'(1);
          if (r_sayac == c_SAYAC_W'(1)) begin
            r_durum <= DUZELT;
          end
        end
        DUZELT: begin
          r_bolum         <= r_neg_q ? -r_bolunen : r_bolunen;
          r_kalan         <= r_neg_r ? -r_artik : r_artik;
          r_sonuc_gecerli <= 1'b1;
          r_durum         <= SONUC;
        end
        SONUC: begin
          if (sonuc_hazir_i) begin
            r_sonuc_gecerli <= 1'b0;
            r_durum         <= BEKLE;
          end
        end
        default: begin
          r_durum <= BEKLE;
        end
      endcase
    end
  end

  assign islem_hazir_o   = (r_durum == BEKLE) && !iptal_i;
  assign bolum_o         = r_bolum;
  assign kalan_o         = r_kalan;
  assign sonuc_gecerli_o = r_sonuc_gecerli;

endmodule

`default_nettype wire

// File: tb/tb_genel_bolucu.sv
// tb_genel_bolucu: directed and random scoreboard bench for genel_bolucu (rev 1.0).
`default_nettype none

module tb_genel_bolucu;

  localparam int W   = 32;
  localparam int BPC = 2;
  localparam int TUR = W / BPC;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic [3:0]   islev_kodu_i = '0;
  logic [W-1:0] islec0_i = '0;
  logic [W-1:0] islec1_i = '0;
  logic         islem_gecerli_i = 1'b0;
  logic         islem_hazir_o;
  logic         iptal_i = 1'b0;
  logic [W-1:0] bolum_o;
  logic [W-1:0] kalan_o;
  logic         sonuc_gecerli_o;
  logic         sonuc_hazir_i = 1'b1;

  always #5 clk = ~clk;

  genel_bolucu #(.VERI_BIT(W), .BIT_PER_CYCLE(BPC)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .islev_kodu_i    (islev_kodu_i),
    .islec0_i        (islec0_i),
    .islec1_i        (islec1_i),
    .islem_gecerli_i (islem_gecerli_i),
    .islem_hazir_o   (islem_hazir_o),
    .iptal_i         (iptal_i),
    .bolum_o         (bolum_o),
    .kalan_o         (kalan_o),
    .sonuc_gecerli_o (sonuc_gecerli_o),
    .sonuc_hazir_i   (sonuc_hazir_i)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           acc;
    int           lat;
  } bek_t;

  bek_t sb[$];
  int   cyc     = 0;
  int   n_check = 0;
  int   n_err   = 0;
  bit   goruldu = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic kontrol(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_check++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: language-level signed/unsigned division plus the documented special cases.
  function automatic bek_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bek_t e;
    logic sgn;
    int   it;
`ifdef GENEL_BOLUCU_ERKEN_CIKIS_EN
    logic [W-1:0] ma;
`endif
    e.acc = 0;
    sgn = (op == 4'h1) || (op == 4'h4);
    if (!((op == 4'h1) || (op == 4'h2) || (op == 4'h4) || (op == 4'h8))) begin
      e.q = '0; e.r = '0; e.lat = 1;
    end else if (b == '0) begin
      e.q = '1; e.r = a; e.lat = 1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = a; e.r = '0; e.lat = 1;
    end else begin
      if (sgn) begin
        e.q = $signed(a) / $signed(b);
        e.r = $signed(a) % $signed(b);
      end else begin
        e.q = a / b;
        e.r = a % b;
      end
      it = TUR;
`ifdef GENEL_BOLUCU_ERKEN_CIKIS_EN
      ma = (sgn && a[W-1]) ? -a : a;
      it = 1;
      while (it < TUR && (ma >> (it * BPC)) != '0) it++;
`endif
      e.lat = it + 2;
    end
    return e;
  endfunction

  task automatic tik();
    @(posedge clk);
    #1;
  endtask

  task automatic gonder_e(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bek_t e);
    int n = 0;
    tik();
    islev_kodu_i    = op;
    islec0_i        = a;
    islec1_i        = b;
    islem_gecerli_i = 1'b1;
    while (!islem_hazir_o && n < 200) begin
      tik();
      n++;
    end
    kontrol("kabul_zaman_asimi", 64'(n < 200), 64'd1);
    if (n < 200) begin
      e.acc = cyc;
      sb.push_back(e);
    end
    tik();
    islem_gecerli_i = 1'b0;
  endtask

  task automatic gonder(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    gonder_e(op, a, b, model(op, a, b));
  endtask

  task automatic gonder_k(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] r);
    bek_t e;
    e   = model(op, a, b);
    e.q = q;
    e.r = r;
    gonder_e(op, a, b, e);
  endtask

  task automatic bosalt();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      tik();
      n++;
    end
    kontrol("bosalma_zaman_asimi", 64'(sb.size() == 0), 64'd1);
    sb.delete();
  endtask

  task automatic sessizlik(input string tag, input int ncyc);
    bit goruldu_yerel = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (sonuc_gecerli_o !== 1'b0) goruldu_yerel = 1'b1;
    end
    kontrol(tag, 64'(goruldu_yerel), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_ni === 1'b1) begin
      if (sonuc_gecerli_o !== 1'b1) begin
        goruldu = 1'b0;
      end else if (sb.size() == 0) begin
        kontrol("beklenmeyen_sonuc", 64'(sb.size()), 64'd1);
      end else begin
        if (!goruldu) begin
          kontrol("gecikme", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
          goruldu = 1'b1;
        end
        kontrol("bolum", 64'(bolum_o), 64'(sb[0].q));
        kontrol("kalan", 64'(kalan_o), 64'(sb[0].r));
        kontrol("sonucta_hazir", 64'(islem_hazir_o), 64'(iptal_i ? 1'b0 : 1'b0));
        if (sonuc_hazir_i) begin
          void'(sb.pop_front());
          goruldu = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           n;

    repeat (3) tik();
    @(negedge clk);
    kontrol("reset_bolum", 64'(bolum_o), 64'd0);
    kontrol("reset_kalan", 64'(kalan_o), 64'd0);
    kontrol("reset_gecerli", 64'(sonuc_gecerli_o), 64'd0);
    tik();
    rst_ni = 1'b1;
    #1;
    kontrol("reset_sonrasi_hazir", 64'(islem_hazir_o), 64'd1);

    gonder_k(4'h2, 32'd100, 32'd7, 32'd14, 32'd2);
    gonder_k(4'h1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    gonder_k(4'h4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    gonder_k(4'h2, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
    gonder_k(4'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    gonder_k(4'h2, 32'd3, 32'd1, 32'd3, 32'd0);
    gonder_k(4'h3, 32'd10, 32'd3, 32'd0, 32'd0);
    gonder_k(4'h0, 32'd10, 32'd0, 32'd0, 32'd0);
    gonder_k(4'h1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    gonder_k(4'h8, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
    gonder_k(4'h8, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    gonder_k(4'h2, 32'd6, 32'd100, 32'd0, 32'd6);
    gonder(4'h1, 32'h8000_0000, 32'd3);
    bosalt();

    // Backpressure: result must hold while the consumer stalls.
    tik();
    sonuc_hazir_i = 1'b0;
    gonder(4'h2, 32'd100, 32'd7);
    n = 0;
    while (sonuc_gecerli_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    kontrol("durak_sonuc_zaman_asimi", 64'(n < 50), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      kontrol("durak_bolum", 64'(bolum_o), 64'd14);
      kontrol("durak_kalan", 64'(kalan_o), 64'd2);
      kontrol("durak_hazir", 64'(islem_hazir_o), 64'd0);
    end
    tik();
    sonuc_hazir_i = 1'b1;
    bosalt();

    // Flush during BOL iteration 8.
    gonder(4'h2, 32'h1234_5678, 32'd3);
    repeat (7) tik();
    iptal_i = 1'b1;
    #1;
    kontrol("iptal_sirasinda_hazir", 64'(islem_hazir_o), 64'd0);
    tik();
    iptal_i = 1'b0;
    #1;
    kontrol("iptal_sonrasi_hazir", 64'(islem_hazir_o), 64'd1);
    sb.delete();
    sessizlik("iptal_sonuc_yok", 25);

    // Flush while a result is waiting in SONUC.
    tik();
    sonuc_hazir_i = 1'b0;
    gonder(4'h2, 32'd9, 32'd0);
    repeat (2) tik();
    iptal_i = 1'b1;
    tik();
    iptal_i = 1'b0;
    sonuc_hazir_i = 1'b1;
    sb.delete();
    @(negedge clk);
    kontrol("sonucta_iptal_gecerli", 64'(sonuc_gecerli_o), 64'd0);
    kontrol("sonucta_iptal_hazir", 64'(islem_hazir_o), 64'd1);

    // Flush has priority over a simultaneous request.
    tik();
    islev_kodu_i    = 4'h2;
    islec0_i        = 32'd4;
    islec1_i        = 32'd0;
    islem_gecerli_i = 1'b1;
    iptal_i         = 1'b1;
    tik();
    islem_gecerli_i = 1'b0;
    iptal_i         = 1'b0;
    sessizlik("iptal_oncelik", 3);

    // Reset in the middle of BOL.
    gonder(4'h2, 32'h0000_FFFF, 32'd3);
    repeat (5) tik();
    rst_ni = 1'b0;
    tik();
    rst_ni = 1'b1;
    sb.delete();
    #1;
    kontrol("orta_reset_hazir", 64'(islem_hazir_o), 64'd1);
    kontrol("orta_reset_bolum", 64'(bolum_o), 64'd0);
    sessizlik("orta_reset_sonuc_yok", 25);

    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom) : (4'h1 << $urandom_range(0, 3));
      a  = $urandom >> $urandom_range(0, 31);
      case ($urandom_range(0, 9))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      gonder(op, a, b);
    end
    bosalt();

    $display("Simulation finished: %0d checks, %0d errors", n_check, n_err);
    $finish;
  end

endmodule

`default_nettype wire
